// File: rtl/pattern_detector.sv
// -----------------------------------------------------------------------------
// pattern_detector
//
// Serial bit-pattern detector with a programmable LEN-bit pattern, a per-bit
// don't-care mask, overlapping/non-overlapping match mode, sample
// qualification and a saturating match counter.
//
// Parameters
//   LEN    pattern length in bits (2..16)
//   CNT_W  width of the match counter
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   en         sample qualifier; `in` is consumed only when en=1
//   in         serial data bit
//   pat        pattern; pat[LEN-1] is the oldest bit, pat[0] the newest
//   mask       per-bit compare enable (1 = compare, 0 = don't care)
//   overlap    1 = overlapping matches, 0 = restart window after a match
//   clr_cnt    synchronous clear of match_cnt (wins over a simultaneous hit)
//   match      registered one-cycle pulse per detected match
//   filled     history holds LEN valid samples in the current window
//   match_cnt  saturating count of matches
// -----------------------------------------------------------------------------
module pattern_detector #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic [LEN-1:0]   pat,
    input  logic [LEN-1:0]   mask,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match,
    output logic             filled,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int             FILL_W  = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Masked compare of a history window against the pattern.
    function automatic logic window_hit(
        input logic [LEN-1:0] h,
        input logic [LEN-1:0] p,
        input logic [LEN-1:0] m
    );
        return (((h ^ p) & m) == {LEN{1'b0}});
    endfunction

    logic [LEN-1:0]    hist_r;
    logic [FILL_W-1:0] fill_r;
    logic              match_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [LEN-1:0]    nh_s;
    logic [FILL_W-1:0] nf_s;
    logic              hit_s;

    // Candidate history/fill for this edge and the qualified hit decision.
    always_comb begin
        nh_s  = {hist_r[LEN-2:0], in};
        nf_s  = fill_r;
        hit_s = 1'b0;
        if (fill_r == FILL_FULL) begin
            nf_s = FILL_FULL;
        end else begin
            nf_s = fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
        end
        // Requiring a full window keeps reset-state zeros from ever matching.
        if (en && (nf_s == FILL_FULL)) begin
            hit_s = window_hit(nh_s, pat, mask);
        end else begin
            hit_s = 1'b0;
        end
    end

    // History and fill advance only on qualified samples; a non-overlapping
    // hit restarts the window on the hit edge itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_r <= {LEN{1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (en) begin
            hist_r <= nh_s;
            if (hit_s && !overlap) begin
                fill_r <= {FILL_W{1'b0}};
            end else begin
                fill_r <= nf_s;
            end
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

    // One-cycle match pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_r <= 1'b0;
        end else begin
            match_r <= hit_s;
        end
    end

    // Saturating match counter; clear takes priority over a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (hit_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign match     = match_r;
    assign match_cnt = cnt_r;
    assign filled    = (fill_r == FILL_FULL);

endmodule

// File: tb/tb_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_pattern_detector
//
// Directed bench for pattern_detector. Two instances share all inputs: one
// with the default 8-bit counter, one with a 2-bit counter for saturation.
// A queue-based reference model tracks the samples of the current window and
// is compared against both instances every cycle; literal expectations per
// scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_pattern_detector;

    localparam int LEN = 4;

    logic           clk;
    logic           rst;
    logic           en;
    logic           in;
    logic [LEN-1:0] pat;
    logic [LEN-1:0] mask;
    logic           overlap;
    logic           clr_cnt;
    logic           match;
    logic           filled;
    logic [7:0]     match_cnt;
    logic           match2;
    logic           filled2;
    logic [1:0]     match_cnt2;

    int checks = 0;
    int errors = 0;
    int dut_pulses = 0;
    int model_pulses = 0;
    logic cmp_on = 1'b0;

    pattern_detector #(.LEN(LEN), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in), .pat(pat), .mask(mask),
        .overlap(overlap), .clr_cnt(clr_cnt),
        .match(match), .filled(filled), .match_cnt(match_cnt)
    );

    pattern_detector #(.LEN(LEN), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .in(in), .pat(pat), .mask(mask),
        .overlap(overlap), .clr_cnt(clr_cnt),
        .match(match2), .filled(filled2), .match_cnt(match_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit   q[$];
    bit   m_hit;
    bit   m_match = 1'b0;
    int   m_cnt8 = 0;
    int   m_cnt2 = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_match = 1'b0;
            m_cnt8  = 0;
            m_cnt2  = 0;
        end else begin
            m_hit = 1'b0;
            if (en) begin
                q.push_back(in);
                if (q.size() > LEN) void'(q.pop_front());
                if (q.size() == LEN) begin
                    m_hit = 1'b1;
                    for (int i = 0; i < LEN; i++) begin
                        // q[0] is the oldest sample, matching pat[LEN-1]
                        if (mask[LEN-1-i] && (q[i] != pat[LEN-1-i])) m_hit = 1'b0;
                    end
                end
                if (m_hit && !overlap) q.delete();
            end
            m_match = m_hit;
            if (m_hit) model_pulses++;
            if (clr_cnt) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end else if (m_hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (cmp_on) begin
            chk("match",      {31'd0, match},      {31'd0, m_match});
            chk("filled",     {31'd0, filled},     {31'd0, (q.size() == LEN)});
            chk("match_cnt",  {24'd0, match_cnt},  m_cnt8);
            chk("match2",     {31'd0, match2},     {31'd0, m_match});
            chk("filled2",    {31'd0, filled2},    {31'd0, (q.size() == LEN)});
            chk("match_cnt2", {30'd0, match_cnt2}, m_cnt2);
            if (match) dut_pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic samp(input logic e, input logic b);
        @(negedge clk);
        en = e;
        in = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) samp(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dut_pulses   = 0;
        model_pulses = 0;
    endtask

    task automatic run_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) samp(1'b1, bits[i]);
    endtask

    task automatic end_scn(input string name, input int pulses, input int cnt8);
        idle(2);
        chk({name, "_dut_pulses"},   dut_pulses,   pulses);
        chk({name, "_model_pulses"}, model_pulses, pulses);
        chk({name, "_cnt"},          {24'd0, match_cnt}, cnt8);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in = 1'b0; pat = 4'b0000; mask = 4'b1111;
        overlap = 1'b1; clr_cnt = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("reset_match",  {31'd0, match},  32'd0);
        chk("reset_filled", {31'd0, filled}, 32'd0);
        chk("reset_cnt",    {24'd0, match_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cmp_on = 1'b1;

        // Overlapping 1011 on 1,0,1,1,0,1,1
        do_reset();
        pat = 4'b1011; mask = 4'b1111; overlap = 1'b1;
        run_bits(16'b1011011, 7);
        end_scn("ovl1011", 2, 2);

        // Non-overlapping: one hit, filled drops right after it
        do_reset();
        overlap = 1'b0;
        run_bits(16'b1011, 4);
        @(posedge clk); #2;
        chk("novl_match_now",  {31'd0, match},  32'd1);
        chk("novl_filled_now", {31'd0, filled}, 32'd0);
        run_bits(16'b011, 3);
        end_scn("novl1011", 1, 1);

        // All-zero pattern needs four real samples
        do_reset();
        pat = 4'b0000; mask = 4'b1111; overlap = 1'b1;
        run_bits(16'b00000, 5);
        end_scn("zeros", 2, 2);

        // Masked 1001 on 1,1,0,1
        do_reset();
        pat = 4'b1001; mask = 4'b1001; overlap = 1'b1;
        run_bits(16'b1101, 4);
        end_scn("mask1001", 1, 1);

        // Same with en=0 and a toggled bit between every sample
        do_reset();
        samp(1'b1, 1'b1); samp(1'b0, 1'b0);
        samp(1'b1, 1'b1); samp(1'b0, 1'b1);
        samp(1'b1, 1'b0); samp(1'b0, 1'b0);
        samp(1'b1, 1'b1);
        end_scn("mask1001_en", 1, 1);

        // 1111 on eight 1s: five pulses, 2-bit counter saturates
        do_reset();
        pat = 4'b1111; mask = 4'b1111; overlap = 1'b1;
        run_bits(16'hFF, 8);
        end_scn("sat", 5, 5);
        chk("sat_cnt2", {30'd0, match_cnt2}, 32'd3);
        // Clear on a hit cycle: pulse still seen, counters zero
        samp(1'b1, 1'b1);
        clr_cnt = 1'b1;
        @(posedge clk); #2;
        chk("clr_match", {31'd0, match},     32'd1);
        chk("clr_cnt",   {24'd0, match_cnt}, 32'd0);
        chk("clr_cnt2",  {30'd0, match_cnt2}, 32'd0);
        @(negedge clk);
        clr_cnt = 1'b0;
        en = 1'b0;

        // Fully masked: one hit per window without overlap, every sample with
        do_reset();
        mask = 4'b0000; overlap = 1'b0;
        run_bits(16'h00A5, 8);
        end_scn("nomask_novl", 2, 2);
        do_reset();
        overlap = 1'b1;
        run_bits(16'h00A5, 8);
        end_scn("nomask_ovl", 5, 5);

        // Async reset mid-cycle discards history and counter
        do_reset();
        pat = 4'b1011; mask = 4'b1111; overlap = 1'b1;
        run_bits(16'b1011101, 7);
        idle(1);
        chk("pre_rst_cnt", {24'd0, match_cnt}, 32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("async_cnt",    {24'd0, match_cnt}, 32'd0);
        chk("async_filled", {31'd0, filled},    32'd0);
        chk("async_match",  {31'd0, match},     32'd0);
        @(negedge clk);
        rst = 1'b1;
        dut_pulses = 0;
        model_pulses = 0;
        run_bits(16'b1, 1);
        end_scn("post_rst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Parametrised serial bit-pattern detector. It generalises the team's fixed three-zeros shift-register detector to a programmable pattern of LEN bits, with a per-bit don't-care mask, an overlapping or non-overlapping match mode, input qualification and a saturating match counter. It sits on a serial data path, samples one bit per enabled clock and emits a registered one-cycle match pulse.

## Interface
- LEN, default 4: pattern length in bits; legal range 2..16.
- CNT_W, default 8: width of the match counter.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- en  input  1  sample qualifier; `in` is consumed only on cycles with en=1.
- in  input  1  serial data bit.
- pat  input  LEN  pattern; pat[LEN-1] is the oldest (first-received) bit, pat[0] the newest.
- mask  input  LEN  compare enable per bit; 1 = compare, 0 = don't care.
- overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- clr_cnt  input  1  synchronous clear of match_cnt.
- match  output  1  registered one-cycle pulse per detected match.
- filled  output  1  history holds at least LEN valid bits since reset or since the last non-overlapping match.
- match_cnt  output  CNT_W  saturating count of matches.

## Operation
- State:
  - hist[LEN-1:0]: shift history; hist[0] is the newest bit.
  - fill: counter 0..LEN, saturating at LEN.
  - match: output register.
  - match_cnt: counter.
- Reset (rst=0, async): hist=0, fill=0, match=0, match_cnt=0, filled=0. All outputs hold these values while rst is low.
- Each rising edge with en=1:
  - Form the candidate history nh = {hist[LEN-2:0], in} and the candidate fill nf = min(fill+1, LEN).
  - hit = (nf==LEN) && ((nh ^ pat) & mask) == 0.
  - Update hist <= nh.
  - Update fill: if hit && !overlap, fill <= 0; otherwise fill <= nf.
  - Update match <= hit.
- Each rising edge with en=0: hist and fill hold; match <= 0. The unsampled bit is ignored.
- match_cnt:
  - If clr_cnt=1, it becomes 0. clr_cnt has priority over a simultaneous hit; match still pulses.
  - Otherwise, if hit=1 and match_cnt < 2^CNT_W-1, it increments.
  - At 2^CNT_W-1 it holds (saturates, never wraps).
- filled = (fill==LEN), driven combinationally from the registered fill.
- A match is never reported from reset-state zeros: LEN real samples are required, which prevents a false hit on an all-zero pattern.
- mask=0 on all bits: every enabled sample with nf==LEN is a hit.
  - In non-overlap mode this gives one hit per LEN samples.
  - In overlap mode it gives a hit on every sample once filled.
- pat, mask and overlap are sampled live on every edge. Changing them mid-stream does not flush the history; the new values apply from the next edge.
- Reset mid-operation discards the history and fill. The next match needs LEN fresh samples.

## Timing
- Latency: match rises one clock after the edge that samples the final pattern bit, and stays high for exactly one cycle.
- Back-to-back pulses are possible in overlap mode (e.g. pattern 1111 on a run of 1s).
- match_cnt reflects a hit in the same cycle that match is high.
- The non-overlap restart takes effect on the hit edge itself, so the next LEN samples form a new window.
- No combinational path from inputs to outputs.

## Test plan
- LEN=4, pat=1011, mask=1111, overlap=1, en=1, stream 1,0,1,1,0,1,1 -> match pulses after the 4th and 7th samples; match_cnt=2.
- Same stream with overlap=0 -> single pulse after the 4th sample; match_cnt=1; filled drops to 0 for the cycle after the hit.
- pat=0000, mask=1111, after reset, stream 0,0,0,0,0 (overlap=1) -> no pulse for samples 1-3, pulses after samples 4 and 5.
- pat=1001, mask=1001, stream 1,1,0,1 -> match; with en=0 interleaved between every bit (and the bit toggled during the en=0 cycles) -> same single match.
- CNT_W=2, overlap=1, pat=1111, mask=1111, 8 consecutive 1s -> 5 pulses, match_cnt saturates at 3. Then clr_cnt=1 on a hit cycle -> match=1 and match_cnt=0.
- Stream 1,0,1, then rst low for one cycle, then 1 -> no match. hist, fill and match_cnt are all 0 immediately on rst assertion, without waiting for a clock edge.
